csidh_corr_seq: RTL and testbench
=================================

CSIDH_CORR_SEQ -- requirements
Module: csidh_corr_seq

Interface
REQ-001 The module SHALL declare parameter NLIMB, default 8, giving the number of 64-bit limbs per 512-bit operand.
REQ-002 The module SHALL declare parameter XLEN, default 64, giving the limb width in bits.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset: g_clk input 1 (clock), then g_resetn input 1 (reset).
REQ-004 The input stream SHALL use: in_valid input 1; in_ready output 1; in_limb input XLEN (limb 0, the least significant, first).
REQ-005 The output stream SHALL use: out_valid output 1; out_ready input 1; out_limb output XLEN; out_last output 1 (marks the final limb).
REQ-006 The ISE port SHALL use: ise_rs1 output XLEN; ise_rs2 output XLEN; ise_imm output 3 (limb index of p); ise_op_andadd output 1; ise_op_sub output 1; ise_rd input XLEN (combinational result from the CSIDH ISE unit).

Function
REQ-007 The block SHALL compute r = a - p, and then r + p if that subtraction borrowed, for an input a in [0, 2p), where p is the CSIDH-512 prime supplied limb-wise by the ISE unit.
REQ-008 The FSM SHALL have two states: LOAD (accept input limbs) and EMIT (produce output limbs), with a 3-bit limb counter idx.
REQ-009 In LOAD the block SHALL drive:
- in_ready=1, out_valid=0;
- ise_op_sub=in_valid, ise_op_andadd=0;
- ise_rs1=in_limb, ise_imm=idx.
REQ-010 On each LOAD handshake the block SHALL store t = ise_rd - bin into buf[idx] and update bin as follows:
- bout = (ise_rd > in_limb unsigned) | (bin & ise_rd==0);
- all limb arithmetic is modulo 2^XLEN.
REQ-011 On the handshake with idx==NLIMB-1, the block SHALL:
- set mask to all-ones if bout=1, else zero;
- clear idx and carry;
- enter EMIT on the next cycle.
REQ-012 In EMIT the block SHALL drive:
- in_ready=0, out_valid=1;
- ise_op_andadd=1, ise_op_sub=0;
- ise_rs1=mask, ise_rs2=buf[idx], ise_imm=idx.
REQ-013 In EMIT the output SHALL be out_limb = ise_rd + carry, and out_last = (idx==NLIMB-1).
REQ-014 On each EMIT handshake the block SHALL update carry = (ise_rd < buf[idx]) | (carry & ise_rd==all-ones) and increment idx.
- After the last beat it SHALL return to LOAD with idx=0 and bin=0.
REQ-015 Latency: the first out_valid SHALL occur exactly one cycle after the 8th input handshake, and under continuous ready one limb SHALL move per cycle.
REQ-016 While out_valid=1 and out_ready=0, out_limb and out_last SHALL hold stable.
REQ-017 The final carry SHALL be discarded, as it is guaranteed for inputs in range.
REQ-018 Behaviour for inputs of 2p or above SHALL be defined only as "8 limbs emitted", with no error signalled.
REQ-019 The ISE op strobes SHALL never be asserted simultaneously.

Reset
REQ-020 Assertion of g_resetn=0 SHALL asynchronously force:
- state=LOAD, idx=0;
- bin=0, carry=0, mask=0;
- out_valid=0;
- buf contents are don't-care.
REQ-021 Reset mid-operation SHALL abandon the partial operand or result, and the next accepted limb SHALL be treated as limb 0.

Configuration
REQ-022 When CSIDH_CORR_STAT_EN is defined, the block SHALL add output corr_added (1 bit), equal to mask[0], valid while out_valid, and reset to 0.
REQ-023 When CSIDH_CORR_STAT_EN is undefined, the port and its logic SHALL be absent, with no change to any other timing.

Structure
REQ-024 A shared package csidh_pkg SHALL hold:
- NLIMB and XLEN constants;
- the FSM state typedef (LOAD, EMIT);
- the p limb constants, for the testbench only.
REQ-025 The block SHALL contain no p constants in RTL; p SHALL come solely via ise_rd.
REQ-026 One sub-module, csidh_corr_limb, SHALL compute the per-limb borrow and carry detection and the ±1 adjust.

Verification
REQ-027 a=p (limb0=0x1b81b90533c6c87b ... limb7=0x65b48e8f740f89bf) SHALL produce 8 zero limbs, with corr_added=0.
REQ-028 a=0 SHALL produce 8 zero limbs, with corr_added=1.
REQ-029 a=p+5 SHALL produce out limb0=5, other limbs 0, and out_last only on beat 7.
REQ-030 a=1 SHALL produce limb0=1, other limbs 0, with the first out_valid exactly 1 cycle after the 8th in handshake.
REQ-031 out_ready low for 3 cycles at beat 3 SHALL hold out_limb stable, and no limb SHALL be lost or duplicated.
REQ-032 g_resetn pulsed after 4 input limbs, followed by a fresh a=p, SHALL produce 8 zero limbs.

Source files
------------

// File: rtl/csidh_pkg.sv
// Shared constants and types for the CSIDH-512 final-correction sequencer.
package csidh_pkg;

  localparam int CSIDH_NLIMB = 8;
  localparam int CSIDH_XLEN  = 64;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } corr_state_e;

  // CSIDH-512 prime, limb 0 first; only the testbench's ISE model uses these.
  localparam logic [63:0] CSIDH_P [8] = '{
    64'h1b81b90533c6c87b, 64'hc2721bf457aca835,
    64'h516730cc1f0b4f25, 64'ha7aac6c567f35507,
    64'h5afbfcc69322c9cd, 64'hb42d083aedc88c42,
    64'hfc8ab0d15e3e4c4a, 64'h65b48e8f740f89bf
  };

endpackage

// File: rtl/csidh_corr_limb.sv
// Per-limb borrow/carry detection and +/-1 adjust around the ISE result.
module csidh_corr_limb #(
  parameter int XLEN = 64
) (
  input  logic            sub_mode_i,
  input  logic [XLEN-1:0] rd_i,
  input  logic [XLEN-1:0] ref_i,
  input  logic            cin_i,
  output logic [XLEN-1:0] res_o,
  output logic            cout_o
);

  logic [XLEN-1:0] cin_ext;
  assign cin_ext = {{(XLEN-1){1'b0}}, cin_i};

  // Subtract: rd = ref - p wrapped iff rd > ref. Add: rd = ref + (mask&p) wrapped iff rd < ref.
  always_comb begin
    if (sub_mode_i) begin
      res_o  = rd_i - cin_ext;
      cout_o = (rd_i > ref_i) | (cin_i & (rd_i == '0));
    end else begin
      res_o  = rd_i + cin_ext;
      cout_o = (rd_i < ref_i) | (cin_i & (rd_i == '1));
    end
  end

endmodule

// File: rtl/csidh_corr_seq.sv
// Conditional subtract-p sequencer: streams in a in [0,2p), streams out a mod p via the ISE unit.
// Optional corr_added status output when CSIDH_CORR_STAT_EN is defined.
//   state | meaning
//   LOAD  | accept limbs, buf[idx] = a - p - borrow
//   EMIT  | output limbs, buf[idx] + (mask & p) + carry
module csidh_corr_seq
  import csidh_pkg::*;
#(
  parameter int NLIMB = CSIDH_NLIMB,
  parameter int XLEN  = CSIDH_XLEN
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_limb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_limb,
  output logic            out_last,
  output logic [XLEN-1:0] ise_rs1,
  output logic [XLEN-1:0] ise_rs2,
  output logic [2:0]      ise_imm,
  output logic            ise_op_andadd,
  output logic            ise_op_sub,
  input  logic [XLEN-1:0] ise_rd
`ifdef CSIDH_CORR_STAT_EN
  ,
  output logic            corr_added
`endif
);

  corr_state_e     state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            bin_q, bin_d;
  logic            carry_q, carry_d;
  logic [XLEN-1:0] mask_q, mask_d;
  logic [XLEN-1:0] buf_q [NLIMB];
  logic [XLEN-1:0] buf_rd;
  logic            buf_we;
  logic            is_last;
  logic            adj_sub;
  logic [XLEN-1:0] adj_ref, adj_res;
  logic            adj_cin, adj_cout;

  assign buf_rd  = buf_q[idx_q];
  assign is_last = (idx_q == 3'(NLIMB-1));
  assign adj_sub = (state_q == LOAD);
  assign adj_ref = adj_sub ? in_limb : buf_rd;
  assign adj_cin = adj_sub ? bin_q : carry_q;

  csidh_corr_limb #(.XLEN(XLEN)) u_limb (
    .sub_mode_i (adj_sub),
    .rd_i       (ise_rd),
    .ref_i      (adj_ref),
    .cin_i      (adj_cin),
    .res_o      (adj_res),
    .cout_o     (adj_cout)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bin_d         = bin_q;
    carry_d       = carry_q;
    mask_d        = mask_q;
    buf_we        = 1'b0;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    out_limb      = '0;
    ise_op_sub    = 1'b0;
    ise_op_andadd = 1'b0;
    ise_rs1       = '0;
    ise_rs2       = '0;
    ise_imm       = idx_q;
    case (state_q)
      LOAD: begin
        in_ready   = 1'b1;
        ise_op_sub = in_valid;
        ise_rs1    = in_limb;
        if (in_valid) begin
          buf_we = 1'b1;
          bin_d  = adj_cout;
          idx_d  = idx_q + 3'd1;
          if (is_last) begin
            mask_d  = {XLEN{adj_cout}};
            idx_d   = 3'd0;
            carry_d = 1'b0;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        out_valid     = 1'b1;
        out_last      = is_last;
        out_limb      = adj_res;
        ise_op_andadd = 1'b1;
        ise_rs1       = mask_q;
        ise_rs2       = buf_rd;
        if (out_ready) begin
          carry_d = adj_cout;
          idx_d   = idx_q + 3'd1;
          if (is_last) begin
            idx_d   = 3'd0;
            bin_d   = 1'b0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= LOAD;
      idx_q   <= 3'd0;
      bin_q   <= 1'b0;
      carry_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bin_q   <= bin_d;
      carry_q <= carry_d;
      mask_q  <= mask_d;
    end
  end

  // Operand buffer needs no reset: every entry is rewritten before EMIT reads it.
  always_ff @(posedge g_clk) begin
    if (buf_we) buf_q[idx_q] <= adj_res;
  end

`ifdef CSIDH_CORR_STAT_EN
  assign corr_added = mask_q[0];
`endif

endmodule

// File: tb/tb_csidh_corr_seq.sv
// Directed bench for csidh_corr_seq with a behavioural ISE unit and an expected-limb queue.
module tb_csidh_corr_seq;
  import csidh_pkg::*;

  logic        g_clk, g_resetn;
  logic        in_valid, in_ready;
  logic [63:0] in_limb;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_limb;
  logic [63:0] ise_rs1, ise_rs2, ise_rd;
  logic [2:0]  ise_imm;
  logic        ise_op_andadd, ise_op_sub;
`ifdef CSIDH_CORR_STAT_EN
  logic        corr_added;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] limb;
    logic        last;
    logic        corr;
  } exp_t;
  exp_t sb[$];

  csidh_corr_seq dut (
    .g_clk         (g_clk),
    .g_resetn      (g_resetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_limb       (in_limb),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_limb      (out_limb),
    .out_last      (out_last),
    .ise_rs1       (ise_rs1),
    .ise_rs2       (ise_rs2),
    .ise_imm       (ise_imm),
    .ise_op_andadd (ise_op_andadd),
    .ise_op_sub    (ise_op_sub),
    .ise_rd        (ise_rd)
`ifdef CSIDH_CORR_STAT_EN
    ,
    .corr_added    (corr_added)
`endif
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Behavioural ISE unit: sub gives rs1 - p[imm], andadd gives rs2 + (rs1 & p[imm]).
  always_comb begin
    ise_rd = '0;
    if (ise_op_sub)         ise_rd = ise_rs1 - CSIDH_P[ise_imm];
    else if (ise_op_andadd) ise_rd = ise_rs2 + (ise_rs1 & CSIDH_P[ise_imm]);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge g_clk) begin
    if (g_resetn === 1'b1) begin
      total++;
      assert (!(ise_op_sub === 1'b1 && ise_op_andadd === 1'b1)) else begin
        bad++;
        $error("FAIL ise_strobes observed=both expected=exclusive");
      end
    end
  end

  function automatic logic [511:0] p512();
    logic [511:0] v;
    for (int i = 0; i < 8; i++) v[64*i +: 64] = CSIDH_P[i];
    return v;
  endfunction

  task automatic push_expected(input logic [511:0] a);
    logic [511:0] pv, r;
    exp_t e;
    pv = p512();
    r  = (a < pv) ? a : a - pv;
    for (int i = 0; i < 8; i++) begin
      e.limb = r[64*i +: 64];
      e.last = (i == 7);
      e.corr = (a < pv);
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [511:0] a, input int nlimbs);
    for (int i = 0; i < nlimbs; i++) begin
      in_valid = 1'b1;
      in_limb  = a[64*i +: 64];
      @(negedge g_clk);
      check("load_in_ready", {63'd0, in_ready}, 64'd1);
      check("load_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge g_clk); #1;
    end
    in_valid = 1'b0;
    in_limb  = '0;
    if (nlimbs == 8) check("latency_out_valid", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic recv(input int stall_beat);
    exp_t        e;
    logic [63:0] held;
    logic        held_last;
    int          n;
    for (int b = 0; b < 8; b++) begin
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        @(posedge g_clk); #1;
        n++;
      end
      check("out_valid_wait", {63'd0, out_valid}, 64'd1);
      if (b == stall_beat) begin
        out_ready = 1'b0;
        held      = out_limb;
        held_last = out_last;
        repeat (3) begin
          @(posedge g_clk); #1;
          check("stall_valid", {63'd0, out_valid}, 64'd1);
          check("stall_limb", out_limb, held);
          check("stall_last", {63'd0, out_last}, {63'd0, held_last});
        end
        out_ready = 1'b1;
      end
      @(negedge g_clk);
      if (sb.size() == 0) begin
        check("sb_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("out_limb[%0d]", b), out_limb, e.limb);
        check($sformatf("out_last[%0d]", b), {63'd0, out_last}, {63'd0, e.last});
`ifdef CSIDH_CORR_STAT_EN
        check($sformatf("corr_added[%0d]", b), {63'd0, corr_added}, {63'd0, e.corr});
`endif
      end
      @(posedge g_clk); #1;
    end
    check("back_to_load_valid", {63'd0, out_valid}, 64'd0);
    check("back_to_load_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run(input logic [511:0] a, input int stall_beat);
    push_expected(a);
    send(a, 8);
    recv(stall_beat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] pv, r;
    logic [512:0] two_p;
    g_resetn  = 1'b0;
    in_valid  = 1'b0;
    in_limb   = '0;
    out_ready = 1'b1;
    pv        = p512();
    two_p     = {pv, 1'b0};

    repeat (2) @(negedge g_clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_op_andadd", {63'd0, ise_op_andadd}, 64'd0);
    check("rst_op_sub", {63'd0, ise_op_sub}, 64'd0);
`ifdef CSIDH_CORR_STAT_EN
    check("rst_corr_added", {63'd0, corr_added}, 64'd0);
`endif
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    @(posedge g_clk); #1;

    run(pv, -1);
    run('0, -1);
    run(pv + 512'd5, -1);
    run(512'd1, -1);
    run(pv - 512'd1, -1);
    run(512'(two_p - 513'd1), -1);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      run(512'({1'b0, r} % two_p), (k == 0) ? 3 : -1);
    end

    send(pv, 4);
    g_resetn = 1'b0;
    #2;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    #4;
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    run(pv, -1);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
